fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, CLK cycles per serial bit; legal range 2..65535.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  reset, synchronous and active-low.
REQ-004 ENABLE  input  1  1 = drain FIFO and transmit; 0 = no new frame starts.
REQ-005 FIFO_DATA  input  8  byte from upstream FIFO DATA_OUT; valid the cycle after FIFO_READ is high.
REQ-006 FIFO_EMPTY_N  input  1  upstream FIFO F_EMPTY_N; 1 = at least one byte available.
REQ-007 FIFO_READ  output  1  one-cycle pop request to upstream FIFO READ.
REQ-008 TX  output  1  serial line, idle high.
REQ-009 BUSY  output  1  1 whenever state is not IDLE.
REQ-010 FRAME_DONE  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; frame length 10*CLKS_PER_BIT.
REQ-012 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-013 IDLE -> FETCH when ENABLE=1 and FIFO_EMPTY_N=1; otherwise remain IDLE with TX=1.
REQ-014 FETCH SHALL last one cycle with FIFO_READ=1; FIFO_READ SHALL be 0 in every other state.
REQ-015 LOAD SHALL last one cycle and capture FIFO_DATA into the 8-bit shift register.
REQ-016 START drives TX=0 starting the cycle after LOAD; FIFO_READ-high cycle to first TX-low cycle = 2 cycles.
REQ-017 DATA shifts one bit per CLKS_PER_BIT cycles; a 3-bit counter selects bits 0..7; leave DATA after bit 7.
REQ-018 Baud counter SHALL count 0..CLKS_PER_BIT-1, clear on every state entry, and its terminal count SHALL advance bit/state.
REQ-019 STOP -> FETCH directly when ENABLE=1 and FIFO_EMPTY_N=1 at the terminal count (no IDLE cycle); else STOP -> IDLE.
REQ-020 ENABLE deasserted mid-frame SHALL NOT abort the frame; frame completes, then IDLE.
REQ-021 FIFO_EMPTY_N falling during a frame SHALL NOT affect the frame in flight.
REQ-022 FIFO_READ SHALL never assert while FIFO_EMPTY_N=0 in the same cycle.
REQ-023 TX SHALL be registered (glitch-free); BUSY and FRAME_DONE registered or decoded from registered state.

Reset
REQ-024 RESET_N=0 at a rising edge SHALL force state IDLE, TX=1, FIFO_READ=0, BUSY=0, FRAME_DONE=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame; TX=1 from the cycle following the reset edge; no byte is re-popped.
REQ-026 No asynchronous reset path SHALL exist.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum type, FRAME_BITS=10, DATA_BITS=8.
REQ-028 One sub-module baud_gen (parameter CLKS_PER_BIT; inputs CLK, RESET_N, CLR; output TICK) SHALL implement the baud counter.
REQ-029 Port names and polarities SHALL connect directly to FIFO_32_8 (DATA_OUT, F_EMPTY_N, READ) without glue.

Verification (CLKS_PER_BIT=4)
REQ-030 Reset then FIFO_EMPTY_N=0, ENABLE=1 for 100 cycles -> FIFO_READ never 1, TX=1, BUSY=0.
REQ-031 Single byte 0xA5 available -> one FIFO_READ pulse; TX = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; FRAME_DONE once; BUSY=0 after.
REQ-032 Four bytes 0x01,0x02,0x04,0x08 queued -> four back-to-back frames, gap between stop bit and next start exactly 2 cycles (FETCH, LOAD), bytes in order.
REQ-033 ENABLE dropped in DATA bit 3 of 0x3C -> frame completes correctly, no further FIFO_READ while ENABLE=0.
REQ-034 RESET_N=0 for 1 cycle in DATA bit 5 -> TX=1 and BUSY=0 next cycle; with FIFO_EMPTY_N=1 and ENABLE=1, next frame begins with a fresh FIFO_READ.
REQ-035 Scoreboard: bytes written to FIFO_32_8 equal bytes decoded from TX; FIFO_READ count equals frames sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the FIFO-fed 8N1 UART transmitter.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses TICK on the terminal count.
module baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLR,
    output logic TICK
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // CLR restarts the period so every state entry gets a full bit time
    always_comb begin
        TICK     = (cnt_reg == TERMINAL);
        cnt_next = (CLR || TICK) ? '0 : cnt_reg + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that pops bytes from an upstream FIFO_32_8 and sends them LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [7:0] FIFO_DATA,
    input  logic       FIFO_EMPTY_N,
    output logic       FIFO_READ,
    output logic       TX,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    uart_state_t          state_reg;
    uart_state_t          state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_next;
    logic                 tx_reg;
    logic                 tx_next;
    logic                 tick;
    logic                 baud_clr;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .CLR    (baud_clr),
        .TICK   (tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (ENABLE && FIFO_EMPTY_N) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Never pop an empty FIFO; fall back to IDLE instead
                state_next = FIFO_EMPTY_N ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                shift_next = FIFO_DATA;
                state_next = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = (ENABLE && FIFO_EMPTY_N) ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        baud_clr = (state_next != state_reg);

        // Line level is computed for the upcoming state so TX comes straight from a flop
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
        end
    end

    assign TX         = tx_reg;
    assign FIFO_READ  = (state_reg == ST_FETCH) && FIFO_EMPTY_N;
    assign BUSY       = (state_reg != ST_IDLE);
    assign FRAME_DONE = (state_reg == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: pushed bytes are expected on TX in order; a line monitor decodes and compares.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int CLKS = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE = 1'b0;
    logic [7:0] FIFO_DATA = '0;
    logic       FIFO_EMPTY_N;
    logic       FIFO_READ;
    logic       TX;
    logic       BUSY;
    logic       FRAME_DONE;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_EMPTY_N(FIFO_EMPTY_N),
        .FIFO_READ   (FIFO_READ),
        .TX          (TX),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int read_seen = 0;
    int fd_count = 0;
    int last_read_cyc = -100;
    int frames_ok = 0;
    int frames_aborted = 0;
    logic mon_en = 1'b0;
    logic [FRAME_BITS-1:0] last_bits = '0;
    logic [7:0] fifo_mem [256];
    logic [7:0] exp_q [$];
    int frame_start_q [$];
    int frame_end_q [$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Upstream FIFO model: registered read, data valid the cycle after READ
    assign FIFO_EMPTY_N = (wr_cnt != rd_cnt);
    always @(posedge CLK) begin
        if (FIFO_READ) begin
            FIFO_DATA <= fifo_mem[rd_cnt[7:0]];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_cnt[7:0]] = b;
        wr_cnt++;
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while ((frames_ok + frames_aborted < target || BUSY) && n < budget) begin
            step();
            n++;
        end
        check({name, "_completed"}, int'(n < budget), 1);
    endtask

    task automatic wait_read(input int r0, input string name);
        int n;
        n = 0;
        while (read_seen == r0 && n < 20) begin
            step();
            n++;
        end
        check({name, "_read_seen"}, int'(n < 20), 1);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (FIFO_READ) begin
                last_read_cyc = cyc;
                read_seen++;
                check("read_only_when_nonempty", int'(FIFO_EMPTY_N), 1);
            end
            if (FRAME_DONE) fd_count++;
        end
    end

    // Line monitor: decodes each frame cycle by cycle and compares against the scoreboard
    initial begin : line_monitor
        logic prev_tx;
        logic abort, glitch, fd_bad, busy_bad;
        logic [FRAME_BITS-1:0] bits;
        logic [7:0] want;
        int start_cyc;
        wait (mon_en);
        prev_tx = 1'b1;
        forever begin
            @(negedge CLK);
            if (RESET_N && prev_tx && !TX) begin
                start_cyc = cyc;
                check("read_to_start_latency", cyc - last_read_cyc, 2);
                abort = 0; glitch = 0; fd_bad = 0; busy_bad = 0; bits = '0;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    for (int c = 0; c < CLKS; c++) begin
                        if (b != 0 || c != 0) @(negedge CLK);
                        if (!RESET_N) begin
                            abort = 1;
                            break;
                        end
                        if (c == 0) bits[b] = TX;
                        else if (TX !== bits[b]) glitch = 1;
                        if (FRAME_DONE !== (b == FRAME_BITS - 1 && c == CLKS - 1)) fd_bad = 1;
                        if (!BUSY) busy_bad = 1;
                    end
                    if (abort) break;
                end
                if (abort) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    frames_aborted++;
                end else begin
                    check("stop_bit", int'(bits[FRAME_BITS-1]), 1);
                    check("bit_period_stable", int'(glitch), 0);
                    check("frame_done_timing", int'(fd_bad), 0);
                    check("busy_during_frame", int'(busy_bad), 0);
                    check("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        check("byte_decoded", int'(bits[8:1]), int'(want));
                    end
                    last_bits = bits;
                    frame_start_q.push_back(start_cyc);
                    frame_end_q.push_back(cyc);
                    frames_ok++;
                end
            end
            prev_tx = TX;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r0, r1, f0, t0, b0;

        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        check("reset_tx", int'(TX), 1);
        check("reset_busy", int'(BUSY), 0);
        check("reset_fifo_read", int'(FIFO_READ), 0);
        check("reset_frame_done", int'(FRAME_DONE), 0);
        step();
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        mon_en  = 1'b1;

        // Enabled but nothing queued: line stays idle
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            check("idle_empty_read_tx_busy", int'({FIFO_READ, TX, BUSY}), int'(3'b010));
        end
        step();

        // Single byte 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 (index 0 first)
        r0 = read_seen; f0 = fd_count; t0 = frames_ok + frames_aborted;
        push(8'hA5);
        wait_frames(t0 + 1, 200, "a5");
        check("a5_read_pulses", read_seen - r0, 1);
        check("a5_frame_done_pulses", fd_count - f0, 1);
        check("a5_line_pattern", int'(last_bits), int'(10'b1101001010));
        check("a5_busy_after", int'(BUSY), 0);

        // Four queued bytes go out back to back, FETCH+LOAD between frames
        b0 = frames_ok; t0 = frames_ok + frames_aborted;
        push(8'h01); push(8'h02); push(8'h04); push(8'h08);
        wait_frames(t0 + 4, 400, "burst");
        check("burst_frames", frames_ok - b0, 4);
        for (int i = 1; i < 4; i++) begin
            if (frame_start_q.size() > b0 + i)
                check("burst_gap", frame_start_q[b0 + i] - frame_end_q[b0 + i - 1], 3);
        end

        // ENABLE dropped during data bit 3: frame finishes, nothing more is popped
        t0 = frames_ok + frames_aborted; r0 = read_seen;
        push(8'h3C);
        wait_read(r0, "en_drop");
        repeat (18) step();
        ENABLE = 1'b0;
        push(8'h99);
        wait_frames(t0 + 1, 200, "en_drop");
        r1 = read_seen;
        repeat (60) step();
        check("no_read_while_disabled", read_seen - r1, 0);
        check("disabled_busy", int'(BUSY), 0);
        check("disabled_tx", int'(TX), 1);
        ENABLE = 1'b1;
        wait_frames(t0 + 2, 200, "reenable");

        // One-cycle reset during data bit 5 aborts the frame; the next byte gets a fresh pop
        t0 = frames_ok + frames_aborted; r0 = read_seen;
        push(8'h5A); push(8'h77);
        wait_read(r0, "mid_reset");
        repeat (26) step();
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        @(negedge CLK);
        check("after_reset_tx", int'(TX), 1);
        check("after_reset_busy", int'(BUSY), 0);
        r1 = read_seen;
        step();
        wait_frames(t0 + 2, 200, "post_reset");
        check("post_reset_fresh_reads", read_seen - r1, 1);
        check("aborted_frames", frames_aborted, 1);

        check("reads_equal_frames", rd_cnt, frames_ok + frames_aborted);
        check("fifo_drained", wr_cnt - rd_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
